// File: rtl/i2c_txn_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_txn_sequencer
//
// Turns one CPU request into a complete I2C transfer by issuing START / byte /
// STOP operations to a byte-level bus engine:
//   optional write phase (0-2 command bytes) -> programmable gap ->
//   optional read phase (0-6 bytes), read bytes collected into a 48-bit buffer.
// Typical use: SHT31-style "write command, wait, read 6 bytes" polling.
//
// Parameters
//   GAP_W      : width of the gap counter
//   GAP_CYCLES : clk cycles between write-phase STOP and read-phase START
//                (0 = no gap)
//
// Ports
//   clk, rst_n      : clock, synchronous active-low reset
//   req_valid/ready : request handshake (ready high only when idle)
//   req_addr        : 7-bit slave address
//   req_wlen        : write byte count 0-2 (3 behaves as 2)
//   req_wdata       : write bytes, [15:8] sent first
//   req_rlen        : read byte count 0-6 (7 behaves as 6)
//   busy            : high from accept until done
//   done            : one-cycle pulse at transfer end
//   err             : slave NACK seen during last transfer
//   rdata / rcount  : read buffer (first byte in [47:40]) / bytes stored
//   eng_valid/ready : engine op request handshake
//   eng_op          : 0 START, 1 WRITE, 2 READ, 3 STOP
//   eng_wdata       : byte for WRITE
//   eng_nack        : on READ, master NACKs this byte
//   eng_done        : one-cycle op-complete pulse from the engine
//   eng_ack         : with eng_done on WRITE, 1 = slave ACKed
//   eng_rdata       : with eng_done on READ, received byte
//   dbg_state       : current FSM state encoding (observation only)
// ---------------------------------------------------------------------------
module i2c_txn_sequencer #(
  parameter int GAP_W      = 20,
  parameter int GAP_CYCLES = 400000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_addr,
  input  logic [1:0]  req_wlen,
  input  logic [15:0] req_wdata,
  input  logic [2:0]  req_rlen,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [47:0] rdata,
  output logic [2:0]  rcount,
  output logic        eng_valid,
  input  logic        eng_ready,
  output logic [1:0]  eng_op,
  output logic [7:0]  eng_wdata,
  output logic        eng_nack,
  input  logic        eng_done,
  input  logic        eng_ack,
  input  logic [7:0]  eng_rdata,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_W_START = 4'd1,
    S_W_ADDR  = 4'd2,
    S_W_DATA  = 4'd3,
    S_W_STOP  = 4'd4,
    S_GAP     = 4'd5,
    S_R_START = 4'd6,
    S_R_ADDR  = 4'd7,
    S_R_DATA  = 4'd8,
    S_R_STOP  = 4'd9,
    S_FINISH  = 4'd10
  } state_t;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  localparam bit             HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  // Request inputs are only looked at in the accept cycle.
  state_t            r_state;
  logic              r_wait;      // op handed to engine, waiting for eng_done
  logic [6:0]        r_addr;
  logic [1:0]        r_wlen;
  logic [15:0]       r_wdata;
  logic [2:0]        r_rlen;
  logic              r_widx;      // index of the command byte in flight
  logic [GAP_W-1:0]  r_gap_cnt;

  logic              r_req_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [47:0]       r_rdata;
  logic [2:0]        r_rcount;
  logic              r_eng_valid;
  logic [1:0]        r_eng_op;
  logic [7:0]        r_eng_wdata;
  logic              r_eng_nack;

  logic [1:0]        w_wlen_eff;
  logic [2:0]        w_rlen_eff;
  logic              w_accept;
  logic              w_op_done;
  logic [2:0]        w_rcount_nxt;

  assign w_wlen_eff   = (req_wlen == 2'd3) ? 2'd2 : req_wlen;
  assign w_rlen_eff   = (req_rlen == 3'd7) ? 3'd6 : req_rlen;
  assign w_accept     = r_req_ready && req_valid;
  assign w_op_done    = r_wait && eng_done;
  assign w_rcount_nxt = r_rcount + 3'd1;

  // Engine handshake: eng_valid is raised together with eng_op/eng_wdata/
  // eng_nack and all four are held unchanged until a cycle with
  // eng_valid && eng_ready. eng_valid drops the following cycle and the op
  // is then owned by the engine until its eng_done pulse; eng_done seen at any
  // other time is ignored. The next op is launched on the eng_done edge, so
  // the sequencer adds exactly one cycle per op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wait      <= 1'b0;
      r_addr      <= 7'd0;
      r_wlen      <= 2'd0;
      r_wdata     <= 16'd0;
      r_rlen      <= 3'd0;
      r_widx      <= 1'b0;
      r_gap_cnt   <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 48'd0;
      r_rcount    <= 3'd0;
      r_eng_valid <= 1'b0;
      r_eng_op    <= OP_START;
      r_eng_wdata <= 8'd0;
      r_eng_nack  <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (r_eng_valid && eng_ready) begin
        r_eng_valid <= 1'b0;
        r_wait      <= 1'b1;
      end

      case (r_state)
        // FINISH is the done cycle; it already accepts the next request.
        S_IDLE, S_FINISH: begin
          if (w_accept) begin
            r_addr      <= req_addr;
            r_wlen      <= w_wlen_eff;
            r_wdata     <= req_wdata;
            r_rlen      <= w_rlen_eff;
            r_widx      <= 1'b0;
            r_rdata     <= 48'd0;
            r_rcount    <= 3'd0;
            r_err       <= 1'b0;
            r_busy      <= 1'b1;
            r_req_ready <= 1'b0;
            // wlen=0 with rlen=0 is an address probe and uses the write phase.
            r_state     <= ((w_wlen_eff != 2'd0) || (w_rlen_eff == 3'd0)) ? S_W_START : S_R_START;
            r_eng_valid <= 1'b1;
            r_eng_op    <= OP_START;
            r_eng_wdata <= 8'd0;
            r_eng_nack  <= 1'b0;
            r_wait      <= 1'b0;
          end else if (r_state == S_FINISH) begin
            r_state <= S_IDLE;
          end
        end

        S_W_START: begin
          if (w_op_done) begin
            r_state     <= S_W_ADDR;
            r_eng_valid <= 1'b1;
            r_eng_op    <= OP_WRITE;
            r_eng_wdata <= {r_addr, 1'b0};
            r_eng_nack  <= 1'b0;
            r_wait      <= 1'b0;
          end
        end

        S_W_ADDR: begin
          if (w_op_done) begin
            r_eng_valid <= 1'b1;
            r_eng_nack  <= 1'b0;
            r_wait      <= 1'b0;
            if (eng_ack && (r_wlen != 2'd0)) begin
              r_state     <= S_W_DATA;
              r_widx      <= 1'b0;
              r_eng_op    <= OP_WRITE;
              r_eng_wdata <= r_wdata[15:8];
            end else begin
              // Address NACK or probe: close the write phase.
              r_err       <= r_err | ~eng_ack;
              r_state     <= S_W_STOP;
              r_eng_op    <= OP_STOP;
              r_eng_wdata <= 8'd0;
            end
          end
        end

        S_W_DATA: begin
          if (w_op_done) begin
            r_eng_valid <= 1'b1;
            r_eng_nack  <= 1'b0;
            r_wait      <= 1'b0;
            if (eng_ack && !r_widx && (r_wlen == 2'd2)) begin
              r_widx      <= 1'b1;
              r_eng_op    <= OP_WRITE;
              r_eng_wdata <= r_wdata[7:0];
            end else begin
              r_err       <= r_err | ~eng_ack;
              r_state     <= S_W_STOP;
              r_eng_op    <= OP_STOP;
              r_eng_wdata <= 8'd0;
            end
          end
        end

        S_W_STOP: begin
          if (w_op_done) begin
            r_wait <= 1'b0;
            if ((r_rlen != 3'd0) && !r_err) begin
              if (HAS_GAP) begin
                r_state   <= S_GAP;
                r_gap_cnt <= GAP_LOAD;
              end else begin
                r_state     <= S_R_START;
                r_eng_valid <= 1'b1;
                r_eng_op    <= OP_START;
                r_eng_wdata <= 8'd0;
                r_eng_nack  <= 1'b0;
              end
            end else begin
              r_state     <= S_FINISH;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_req_ready <= 1'b1;
            end
          end
        end

        // Counter runs GAP_CYCLES cycles (GAP_CYCLES-1 down to 0 inclusive).
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state     <= S_R_START;
            r_eng_valid <= 1'b1;
            r_eng_op    <= OP_START;
            r_eng_wdata <= 8'd0;
            r_eng_nack  <= 1'b0;
            r_wait      <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end

        S_R_START: begin
          if (w_op_done) begin
            r_state     <= S_R_ADDR;
            r_eng_valid <= 1'b1;
            r_eng_op    <= OP_WRITE;
            r_eng_wdata <= {r_addr, 1'b1};
            r_eng_nack  <= 1'b0;
            r_wait      <= 1'b0;
          end
        end

        S_R_ADDR: begin
          if (w_op_done) begin
            r_eng_valid <= 1'b1;
            r_eng_wdata <= 8'd0;
            r_wait      <= 1'b0;
            if (eng_ack) begin
              r_state    <= S_R_DATA;
              r_eng_op   <= OP_READ;
              r_eng_nack <= (r_rlen == 3'd1);
            end else begin
              r_err      <= 1'b1;
              r_state    <= S_R_STOP;
              r_eng_op   <= OP_STOP;
              r_eng_nack <= 1'b0;
            end
          end
        end

        S_R_DATA: begin
          if (w_op_done) begin
            for (int i = 0; i < 6; i++) begin
              if (r_rcount == 3'(i)) r_rdata[47-8*i -: 8] <= eng_rdata;
            end
            r_rcount    <= w_rcount_nxt;
            r_eng_valid <= 1'b1;
            r_eng_wdata <= 8'd0;
            r_wait      <= 1'b0;
            if (w_rcount_nxt == r_rlen) begin
              r_state    <= S_R_STOP;
              r_eng_op   <= OP_STOP;
              r_eng_nack <= 1'b0;
            end else begin
              // Master NACK only on the final byte of the read.
              r_eng_op   <= OP_READ;
              r_eng_nack <= (w_rcount_nxt == (r_rlen - 3'd1));
            end
          end
        end

        S_R_STOP: begin
          if (w_op_done) begin
            r_wait      <= 1'b0;
            r_state     <= S_FINISH;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign rcount    = r_rcount;
  assign eng_valid = r_eng_valid;
  assign eng_op    = r_eng_op;
  assign eng_wdata = r_eng_wdata;
  assign eng_nack  = r_eng_nack;
  assign dbg_state = r_state;

endmodule
